// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad row by row, debounces whole scans, strobes accepted key codes
//   clock_100Mhz, reset       : clock and synchronous active-high reset
//   Row_Drive                 : active-low row strobes, one row low at a time
//   Col_Sense                 : active-low column inputs, already synchronised
//   key_code/key_valid/key_held : last accepted code, one-cycle accept strobe, single-key-held flag
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    output logic [3:0] Row_Drive,
    input  logic [3:0] Col_Sense,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int TW = $clog2(SCAN_TICKS);
    localparam int SW = DEBOUNCE_SCANS > 1 ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [SW-1:0] STABLE_TOP = SW'(DEBOUNCE_SCANS - 1);
    // nibble index is {row, col}; row 0 col 0 sits in the lowest nibble
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;
    typedef enum logic [1:0] {NONE, KEY, MULTI} kind_e;
    typedef struct packed {
        kind_e      kind;
        logic [3:0] pos;
    } res_t;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    row_q, row_d;
    kind_e         acc_kind_q, acc_kind_d;
    logic [3:0]    acc_pos_q, acc_pos_d;
    res_t          prev_q, prev_d, deb_q, deb_d;
    logic [SW-1:0] stable_q, stable_d, stable_next;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d, key_held_q, key_held_d;
    logic [3:0]    low;
    logic [2:0]    low_n;
    logic [1:0]    col;
    logic          sample, scan_end, accept, is_key;
    kind_e         m_kind;
    logic [3:0]    m_pos;
    res_t          res;
    always_comb begin
        low = ~Col_Sense;
        low_n = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
        col = low[3] ? 2'd0 : low[2] ? 2'd1 : low[1] ? 2'd2 : 2'd3;
        sample = tick_q == TICK_LAST;
        scan_end = sample && row_q == 2'd3;
        // merge this row into the running scan result
        m_kind = (acc_kind_q == MULTI || low_n > 3'd1 || (acc_kind_q == KEY && low_n == 3'd1)) ? MULTI :
                 (acc_kind_q == KEY || low_n == 3'd1) ? KEY : NONE;
        m_pos = (acc_kind_q == NONE && low_n == 3'd1) ? {row_q, col} : acc_pos_q;
        // position is zeroed unless a single key so NONE/MULTI compare equal scan to scan
        res.kind = m_kind;
        res.pos = m_kind == KEY ? m_pos : 4'd0;
        tick_d = sample ? '0 : tick_q + 1'b1;
        row_d = sample ? row_q + 2'd1 : row_q;
        acc_kind_d = sample ? (scan_end ? NONE : m_kind) : acc_kind_q;
        acc_pos_d = sample ? (scan_end ? 4'd0 : m_pos) : acc_pos_q;
        stable_next = res == prev_q ? (stable_q == STABLE_TOP ? stable_q : stable_q + 1'b1) : '0;
        accept = scan_end && stable_next == STABLE_TOP && res != deb_q;
        stable_d = scan_end ? stable_next : stable_q;
        prev_d = scan_end ? res : prev_q;
        deb_d = accept ? res : deb_q;
        is_key = res.kind == KEY;
        key_valid_d = accept && is_key;
        key_code_d = (accept && is_key) ? KEY_MAP[{res.pos, 2'b00} +: 4] : key_code_q;
        key_held_d = accept ? is_key : key_held_q;
    end
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            tick_q      <= '0;
            row_q       <= 2'd0;
            acc_kind_q  <= NONE;
            acc_pos_q   <= 4'd0;
            prev_q      <= '{NONE, 4'd0};
            deb_q       <= '{NONE, 4'd0};
            stable_q    <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            row_q       <= row_d;
            acc_kind_q  <= acc_kind_d;
            acc_pos_q   <= acc_pos_d;
            prev_q      <= prev_d;
            deb_q       <= deb_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end
    assign Row_Drive = ~(4'b1000 >> row_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of row scan order, debounce, multi-key, roll-over and reset behaviour
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_drive, col_sense, key_code;
    logic        key_valid, key_held;
    logic [15:0] keys = 16'h0;
    logic [3:0]  row_tbl [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    int          passed = 0, total = 0, pulses = 0;

    keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(2)) dut (
        .clock_100Mhz(clk),
        .reset(rst),
        .Row_Drive(row_drive),
        .Col_Sense(col_sense),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_sense = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_drive[3-r] && keys[r*4+c]) col_sense[3-c] = 1'b0;
    end

    always @(negedge clk) if (key_valid) pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        chk("rst_row", row_drive, 4'b0111);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        rst = 1'b0;
        pulses = 0;
    endtask

    initial begin
        do_reset();
        for (int k = 0; k < 40; k++) begin
            chk("row_order", row_drive, row_tbl[(k / 4) % 4]);
            tick(1);
        end
        chk("idle_pulses", pulses, 0);

        keys = 16'h0020;
        do_reset();
        tick(31);
        chk("k5_early", key_valid, 1'b0);
        tick(1);
        chk("k5_valid", key_valid, 1'b1);
        chk("k5_code", key_code, 4'h5);
        chk("k5_held", key_held, 1'b1);
        tick(1);
        chk("k5_one_cycle", key_valid, 1'b0);
        tick(63);
        chk("k5_pulses", pulses, 1);
        chk("k5_still_held", key_held, 1'b1);
        keys = 16'h0;
        tick(31);
        chk("rel_held_early", key_held, 1'b1);
        tick(1);
        chk("rel_held", key_held, 1'b0);
        chk("rel_code", key_code, 4'h5);
        chk("rel_pulses", pulses, 1);

        keys = 16'h0;
        do_reset();
        for (int s = 0; s < 10; s++) begin
            keys = (s % 2 == 0) ? 16'h0008 : 16'h0;
            tick(16);
        end
        chk("bounce_pulses", pulses, 0);
        chk("bounce_held", key_held, 1'b0);

        keys = 16'h0005;
        do_reset();
        tick(48);
        chk("multi_pulses", pulses, 0);
        chk("multi_held", key_held, 1'b0);
        keys = 16'h0001;
        tick(32);
        chk("multi_rel_pulses", pulses, 1);
        chk("multi_rel_code", key_code, 4'h1);
        chk("multi_rel_held", key_held, 1'b1);

        keys = 16'h0100;
        do_reset();
        tick(32);
        chk("roll_p1", pulses, 1);
        chk("roll_code7", key_code, 4'h7);
        keys = 16'h8000;
        tick(32);
        chk("roll_p2", pulses, 2);
        chk("roll_codeD", key_code, 4'hD);
        chk("roll_held", key_held, 1'b1);

        keys = 16'h1000;
        do_reset();
        tick(32);
        chk("k0_held", key_held, 1'b1);
        chk("k0_p1", pulses, 1);
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        pulses = 0;
        chk("midrst_row", row_drive, 4'b0111);
        chk("midrst_valid", key_valid, 1'b0);
        chk("midrst_held", key_held, 1'b0);
        chk("midrst_code", key_code, 4'h0);
        tick(31);
        chk("k0_early", key_valid, 1'b0);
        tick(1);
        chk("k0_valid", key_valid, 1'b1);
        chk("k0_code", key_code, 4'h0);
        chk("k0_held2", key_held, 1'b1);
        tick(2);
        chk("k0_pulses", pulses, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver, for the 4x4 Pmod keypad on the Basys 3 board.
- Scans four active-low row lines one at a time, the same way the display scans its anodes, and samples four active-low column lines.
- Debounces the result over whole scans.
- Emits a one-cycle strobe with a 4-bit hex key code per new press. The game logic consumes it and may forward the code to the display.

Parameters:
- SCAN_TICKS, 100000, clocks each row is driven before its columns are sampled (1 ms at 100 MHz); legal values >= 2.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to accept a new key state; legal values >= 1.

Ports:
- clock_100Mhz  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- Row_Drive  output  4  active-low row strobes; exactly one bit low at all times.
- Col_Sense  input  4  active-low column inputs with external pull-ups; already synchronised upstream.
- key_code  output  4  hex code of the last accepted key; held until the next accepted press.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the debounced state is exactly one key pressed.

Behaviour:
- One clock domain; all state updates on the rising edge of clock_100Mhz.
- Reset is synchronous, active-high, and takes priority over all other logic. Reset values:
  - Row_Drive = 4'b0111; key_code = 0; key_valid = 0; key_held = 0.
  - Tick counter and row index = 0; scan accumulator cleared.
  - Previous-scan result = NONE; stable count = 0; debounced state = NONE.
- Reset mid-scan or mid-hold abandons the scan. No pulse is generated by the reset itself.
- Row mapping: row r drives bit (3-r) low, so row 0 = 4'b0111, row 1 = 4'b1011, row 2 = 4'b1101, row 3 = 4'b1110. Column c is read on Col_Sense[3-c], active low.
- Tick counter runs 0..SCAN_TICKS-1. On the cycle where it equals SCAN_TICKS-1:
  - Col_Sense is sampled for the current row.
  - The counter wraps to 0.
  - The row index advances (3 wraps to 0), and Row_Drive updates on the same edge.
- Full scan period = 4*SCAN_TICKS clocks.
- Scan accumulator, over rows 0..3, classifies the scan result as:
  - NONE: no low column seen.
  - KEY(r,c): exactly one low column bit across the whole scan.
  - MULTI: two or more low bits, in the same row or different rows.
- Key map, row-major (col 0..3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Scan end is the row-3 sample edge. On that edge the final result includes row 3, and the debounce compares it with the previous-scan result:
  - If equal: stable count increments, saturating at DEBOUNCE_SCANS-1.
  - If different: stable count = 0.
  - The previous-scan result is then replaced and the accumulator cleared for the next scan.
- Acceptance: the result is accepted when, after the update, the stable count equals DEBOUNCE_SCANS-1 and the result differs from the debounced state. With DEBOUNCE_SCANS = 1, every scan result is accepted immediately.
- On acceptance the debounced state takes the result, registered, so outputs are visible in the cycle after the scan-end edge:
  - KEY: key_code = mapped code, key_valid = 1 for exactly one cycle, key_held = 1.
    - This applies to NONE->KEY, MULTI->KEY and KEY(x)->KEY(y) without release.
  - NONE or MULTI: key_held = 0, key_valid stays 0, key_code unchanged.
- No auto-repeat: a held key produces exactly one pulse.
- No other output changes between scan-end edges.

Test Plan:
- Row order: SCAN_TICKS=4, no keys, 40 clocks after reset release -> Row_Drive cycles 0111,1011,1101,1110 every 4 clocks starting at 0111; key_valid never asserts.
- Single press: SCAN_TICKS=4, DEBOUNCE_SCANS=2; keypad model pulls column 1 low whenever Row_Drive=4'b1011 (key "5"), held for 6 scans -> exactly one key_valid pulse at the end of the second full scan with the key present, key_code=4'h5, key_held=1; release -> key_held=0 after 2 clean scans, no pulse, key_code stays 4'h5.
- Bounce: key "A" (row 0, col 3) asserted on alternate scans for 10 scans -> no key_valid, key_held stays 0.
- Multi-key: "1" and "3" held together (row 0, cols 0 and 2) -> no pulse, key_held=0; then release "3" -> one pulse with key_code=4'h1.
- Roll-over: "7" held (pulse, code 4'h7), then switch to "D" (row 3, col 3) without release -> second pulse with code 4'hD.
- Reset mid-hold: reset one cycle while "0" is held and key_held=1 -> next cycle all outputs at reset values and Row_Drive=0111; with the key still held, a new pulse with code 4'h0 follows after DEBOUNCE_SCANS full scans.
